// File: rtl/enc4_2_serial.sv
// Sequential 4-to-2 encoder: captures a request vector, then emits the index of
// each set bit one per output handshake, in the priority order set by HIGH_FIRST.
//
// state | meaning
// IDLE  | waiting for a vector; in_ready follows en
// BUSY  | draining pend, one code per out_valid/out_ready handshake
module enc4_2_serial #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic       out_last,
    output logic       err_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pend;
    logic [3:0] w_pend_nxt;
    logic       r_err_zero;
    logic       w_err_zero_nxt;
    logic [1:0] w_sel;
    logic       w_one_left;
    logic       w_accept;

    always_comb begin
        w_sel = 2'd0;
        if (HIGH_FIRST) begin
            if (r_pend[3])      w_sel = 2'd3;
            else if (r_pend[2]) w_sel = 2'd2;
            else if (r_pend[1]) w_sel = 2'd1;
            else                w_sel = 2'd0;
        end else begin
            if (r_pend[0])      w_sel = 2'd0;
            else if (r_pend[1]) w_sel = 2'd1;
            else if (r_pend[2]) w_sel = 2'd2;
            else if (r_pend[3]) w_sel = 2'd3;
            else                w_sel = 2'd0;
        end
    end

    assign w_one_left = (r_pend != 4'd0) && ((r_pend & (r_pend - 4'd1)) == 4'd0);

    // rst_n is folded in so in_ready stays low while reset is asserted
    assign in_ready  = (r_state == IDLE) && en && rst_n;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = (r_state == BUSY);
    assign out_code  = out_valid ? w_sel : 2'd0;
    assign out_last  = out_valid && w_one_left;
    assign err_zero  = r_err_zero;

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_err_zero_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_vec != 4'd0) begin
                        w_pend_nxt  = in_vec;
                        w_state_nxt = BUSY;
                    end else begin
                        w_err_zero_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    w_pend_nxt = r_pend & ~(4'b0001 << w_sel);
                    if (w_one_left) w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend     <= 4'd0;
            r_err_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_err_zero <= w_err_zero_nxt;
        end
    end

endmodule

// File: tb/tb_enc4_2_serial.sv
// Bench for enc4_2_serial: both priority orders side by side, a scoreboard of
// expected codes per handshake, a vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_enc4_2_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vec = 4'd0;
    logic       out_ready = 1'b0;

    logic       ir_h, ov_h, ol_h, ez_h;
    logic [1:0] oc_h;
    logic       ir_l, ov_l, ol_l, ez_l;
    logic [1:0] oc_l;

    always #5 clk = ~clk;

    enc4_2_serial #(.HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir_h),
        .in_vec(in_vec), .out_valid(ov_h), .out_ready(out_ready), .out_code(oc_h),
        .out_last(ol_h), .err_zero(ez_h)
    );

    enc4_2_serial #(.HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir_l),
        .in_vec(in_vec), .out_valid(ov_l), .out_ready(out_ready), .out_code(oc_l),
        .out_last(ol_l), .err_zero(ez_l)
    );

    typedef struct {
        logic [1:0] c_hi;
        logic [1:0] c_lo;
        logic       last;
    } exp_t;

    typedef struct {
        logic [3:0] vec;
        logic [7:0] hi_seq;
        logic [7:0] lo_seq;
        int         n;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int         n_total = 0;
    int         n_pass = 0;
    logic       exp_err = 1'b0;
    logic [3:0] rt_hi, rt_lo;
    logic [7:0] log_hi, log_lo;
    int         rt_n;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_log();
        rt_hi = 4'd0; rt_lo = 4'd0; log_hi = 8'd0; log_lo = 8'd0; rt_n = 0;
    endtask

    // expected code sequences built bit by bit from the captured vector
    task automatic push_model(input logic [3:0] v);
        logic [1:0] hi[4];
        logic [1:0] lo[4];
        int nh, nl;
        exp_t e;
        nh = 0; nl = 0;
        for (int b = 3; b >= 0; b--) if (v[b]) begin hi[nh] = 2'(b); nh++; end
        for (int b = 0; b < 4; b++)  if (v[b]) begin lo[nl] = 2'(b); nl++; end
        for (int i = 0; i < nh; i++) begin
            e.c_hi = hi[i]; e.c_lo = lo[i]; e.last = (i == nh - 1);
            sb.push_back(e);
        end
    endtask

    // called just after a negedge with inputs already driven; advances one cycle
    task automatic eval_cycle();
        exp_t e;
        logic ev, acc;
        #1;
        ev = (sb.size() != 0);
        if (ev) e = sb[0];
        else begin e.c_hi = 2'd0; e.c_lo = 2'd0; e.last = 1'b0; end
        chk("in_ready_hi", 8'(ir_h), 8'(!ev && en && rst_n));
        chk("in_ready_lo", 8'(ir_l), 8'(!ev && en && rst_n));
        chk("out_valid_hi", 8'(ov_h), 8'(ev));
        chk("out_valid_lo", 8'(ov_l), 8'(ev));
        chk("out_code_hi", 8'(oc_h), 8'(e.c_hi));
        chk("out_code_lo", 8'(oc_l), 8'(e.c_lo));
        chk("out_last_hi", 8'(ol_h), 8'(e.last));
        chk("out_last_lo", 8'(ol_l), 8'(e.last));
        chk("err_zero_hi", 8'(ez_h), 8'(exp_err));
        chk("err_zero_lo", 8'(ez_l), 8'(exp_err));
        acc = !ev && en && in_valid && rst_n;
        exp_err = acc && (in_vec == 4'd0);
        if (ev && out_ready) begin
            rt_hi  = rt_hi | (4'b0001 << oc_h);
            rt_lo  = rt_lo | (4'b0001 << oc_l);
            log_hi = log_hi | (8'(oc_h) << (2 * rt_n));
            log_lo = log_lo | (8'(oc_l) << (2 * rt_n));
            rt_n++;
            void'(sb.pop_front());
        end
        if (acc && in_vec != 4'd0) push_model(in_vec);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12; i++) begin
            if (sb.size() == 0) break;
            eval_cycle();
        end
        chk(name, 8'(sb.size()), 8'd0);
    endtask

    task automatic run_vec(input logic [3:0] v);
        clear_log();
        en = 1'b1; in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
        eval_cycle();
        in_valid = 1'b0; in_vec = 4'($urandom);
        drain("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b1010, 8'h07, 8'h0D, 2};
        tbl[1] = '{4'b1101, 8'h0B, 8'h38, 3};
        tbl[2] = '{4'b0110, 8'h06, 8'h09, 2};
        tbl[3] = '{4'b0011, 8'h01, 8'h04, 2};
        tbl[4] = '{4'b1111, 8'h1B, 8'hE4, 4};
        tbl[5] = '{4'b0100, 8'h02, 8'h02, 1};
        clear_log();

        // reset state, with en and in_valid high to show nothing leaks through
        en = 1'b1; in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 8'({ir_h, ir_l}), 8'd0);
        chk("rst_out_valid", 8'({ov_h, ov_l}), 8'd0);
        chk("rst_out_code", 8'({oc_h, oc_l}), 8'd0);
        chk("rst_out_last", 8'({ol_h, ol_l}), 8'd0);
        chk("rst_err_zero", 8'({ez_h, ez_l}), 8'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) eval_cycle();

        // table vectors: exact emitted order against hand-written sequences
        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t].vec);
            chk("tbl_seq_hi", log_hi, tbl[t].hi_seq);
            chk("tbl_seq_lo", log_lo, tbl[t].lo_seq);
            chk("tbl_count", 8'(rt_n), 8'(tbl[t].n));
        end
        eval_cycle();

        // round trip through a 2-to-4 decode for every nonzero vector
        for (int v = 1; v < 16; v++) begin
            run_vec(4'(v));
            chk("rt_or_hi", 8'(rt_hi), 8'(v));
            chk("rt_or_lo", 8'(rt_lo), 8'(v));
            chk("rt_count", 8'(rt_n), 8'($countones(4'(v))));
        end

        // backpressure: code holds, a competing vector is never taken
        clear_log();
        en = 1'b1; in_valid = 1'b1; in_vec = 4'b0110; out_ready = 1'b0;
        eval_cycle();
        in_vec = 4'b0001;
        repeat (5) eval_cycle();
        chk("bp_hold_code", 8'(oc_h), 8'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_seq_hi", log_hi, 8'h06);
        eval_cycle();
        chk("bp_no_capture", 8'(ov_h), 8'd0);

        // zero vector
        in_valid = 1'b1; in_vec = 4'd0; en = 1'b1;
        eval_cycle();
        in_valid = 1'b0;
        chk("zero_err_pulse", 8'({ez_h, ez_l}), 8'h3);
        repeat (2) eval_cycle();

        // en low in IDLE blocks capture
        en = 1'b0; in_valid = 1'b1; in_vec = 4'b0100;
        repeat (3) eval_cycle();
        in_valid = 1'b0; en = 1'b1;
        eval_cycle();

        // en dropped mid-drain
        clear_log();
        in_valid = 1'b1; in_vec = 4'b0011; out_ready = 1'b1;
        eval_cycle();
        in_valid = 1'b0; en = 1'b0;
        drain("en_drain");
        chk("en_drain_count", 8'(rt_n), 8'd2);
        eval_cycle();
        en = 1'b1;
        eval_cycle();

        // reset in the middle of a drain
        clear_log();
        in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
        eval_cycle();
        in_valid = 1'b0;
        eval_cycle();
        chk("mid_first_code", log_hi, 8'h03);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 8'({ov_h, ov_l}), 8'd0);
        chk("mid_rst_in_ready", 8'({ir_h, ir_l}), 8'd0);
        chk("mid_rst_code", 8'({oc_h, oc_l}), 8'd0);
        sb.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; en = 1'b1;
        repeat (4) eval_cycle();
        chk("mid_rst_ready_after", 8'({ir_h, ir_l}), 8'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
